// File: rtl/gauss_row_fetch.sv
// Row fetcher for the 10-row Gaussian line buffer: reads image rows from SRAM, then flushes zero rows.
// Optional build macro GAUSS_ROW_FETCH_CNT_EN adds the rows_out delivered-row counter.
module gauss_row_fetch #(
  parameter int DATA_W     = 5120,
  parameter int ADDR_W     = 10,
  parameter int RD_LAT     = 1,
  parameter int FLUSH_ROWS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic              hold,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              buffer_we,
  output logic [2:0]        buffer_mode,
  output logic              busy,
  output logic              done
`ifdef GAUSS_ROW_FETCH_CNT_EN
  ,
  output logic [ADDR_W-1:0] rows_out
`endif
);

  localparam int FCW = (FLUSH_ROWS > 1) ? $clog2(FLUSH_ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FETCH, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   base_q, num_q, issued;
  logic [FCW-1:0]      flush_cnt;
  logic [RD_LAT-1:0]   vpipe;
  logic                issue, accept;

  // Handshake: sram_re=1 with sram_addr is a read accepted that cycle; its data is
  // on sram_rdata RD_LAT cycles later. buffer_we=1 marks out_data as a valid row for
  // exactly that cycle; there is no back-pressure from the buffer side.
  assign accept = (state == S_IDLE) && start && !abort;

  always_comb begin
    state_n     = state;
    issue       = 1'b0;
    sram_re     = 1'b0;
    sram_addr   = '0;
    buffer_mode = 3'd0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_n = (num_rows == '0) ? S_DONE : S_ARM;
      end
      S_ARM: begin
        buffer_mode = 3'd1;
        state_n     = S_FETCH;
      end
      S_FETCH: begin
        buffer_mode = 3'd1;
        if (!hold) begin
          issue     = 1'b1;
          sram_re   = 1'b1;
          sram_addr = base_q + issued;
          if (issued == num_q - ADDR_W'(1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        buffer_mode = 3'd1;
        // Empty valid pipe means the last row is on out_data this cycle.
        if (vpipe == '0) state_n = (FLUSH_ROWS == 0) ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        buffer_mode = 3'd1;
        if (flush_cnt == FCW'(FLUSH_ROWS - 1)) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n   = S_IDLE;
      issue     = 1'b0;
      sram_re   = 1'b0;
      sram_addr = '0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      issued    <= '0;
      flush_cnt <= '0;
      vpipe     <= '0;
      out_data  <= '0;
      buffer_we <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        base_q <= base_addr;
        num_q  <= num_rows;
        issued <= '0;
      end else if (issue) begin
        issued <= issued + ADDR_W'(1);
      end
      if (state == S_FLUSH && state_n == S_FLUSH) flush_cnt <= flush_cnt + FCW'(1);
      else                                        flush_cnt <= '0;
      if (abort) begin
        vpipe     <= '0;
        out_data  <= '0;
        buffer_we <= 1'b0;
      end else begin
        vpipe[0] <= sram_re;
        for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
        buffer_we <= vpipe[RD_LAT-1];
        out_data  <= vpipe[RD_LAT-1] ? sram_rdata : '0;
      end
    end
  end

`ifdef GAUSS_ROW_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              rows_out <= '0;
    else if (accept)                      rows_out <= '0;
    else if (buffer_we && rows_out != '1) rows_out <= rows_out + ADDR_W'(1);
  end
`endif

endmodule

// File: tb/tb_gauss_row_fetch.sv
// Bench for gauss_row_fetch: two instances (read latency 1 and 2) share stimulus and are
// compared cycle by cycle with a per-run reference trace built from the fetch rules.
module tb_gauss_row_fetch;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int FR = 9;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          rst, start, abort, hold;
  logic [AW-1:0] base_addr, num_rows;

  logic          sre_a, sre_b, bwe_a, bwe_b, busy_a, busy_b, done_a, done_b;
  logic [AW-1:0] saddr_a, saddr_b, rows_out_a, rows_out_b;
  logic [DW-1:0] srdata_a, srdata_b, odata_a, odata_b, junk;
  logic [2:0]    bmode_a, bmode_b;

  logic          pa_v, pb_v1, pb_v2;
  logic [AW-1:0] pa_a, pb_a1, pb_a2;

  int checks = 0;
  int errors = 0;

  bit            h [W];
  logic          e_re   [2][W];
  logic [AW-1:0] e_addr [2][W];
  logic          e_we   [2][W];
  logic [2:0]    e_mode [2][W];
  logic          e_busy [2][W];
  logic          e_done [2][W];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            exp_rows [2];
  int            obs_done_a, first_we_a;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {22'h2A5A5A ^ {12'b0, a}, a, 32'(a) * 32'h9E3779B1};
  endfunction

  // SRAM models: data appears RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    junk  <= {$urandom, $urandom};
    pa_v  <= sre_a;  pa_a  <= saddr_a;
    pb_v1 <= sre_b;  pb_a1 <= saddr_b;
    pb_v2 <= pb_v1;  pb_a2 <= pb_a1;
  end
  assign srdata_a = pa_v  ? mem(pa_a)  : junk;
  assign srdata_b = pb_v2 ? mem(pb_a2) : junk;

  gauss_row_fetch #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .FLUSH_ROWS(FR)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .num_rows(num_rows), .hold(hold), .sram_re(sre_a), .sram_addr(saddr_a),
    .sram_rdata(srdata_a), .out_data(odata_a), .buffer_we(bwe_a), .buffer_mode(bmode_a),
    .busy(busy_a), .done(done_a)
`ifdef GAUSS_ROW_FETCH_CNT_EN
    , .rows_out(rows_out_a)
`endif
  );

  gauss_row_fetch #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .FLUSH_ROWS(FR)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .num_rows(num_rows), .hold(hold), .sram_re(sre_b), .sram_addr(saddr_b),
    .sram_rdata(srdata_b), .out_data(odata_b), .buffer_we(bwe_b), .buffer_mode(bmode_b),
    .busy(busy_b), .done(done_b)
`ifdef GAUSS_ROW_FETCH_CNT_EN
    , .rows_out(rows_out_b)
`endif
  );

`ifndef GAUSS_ROW_FETCH_CNT_EN
  assign rows_out_a = '0;
  assign rows_out_b = '0;
`endif

  task automatic chk(input string tag, input int c, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Reference trace: start in cycle 0, ARM in 1, issues from cycle 2 on every non-held
  // cycle, each row written lat+1 cycles after its read, FR quiet cycles, then done.
  task automatic build_exp(input int d, input int lat, input logic [AW-1:0] b, input int n, input int ab);
    int issued = 0;
    int last = 0;
    int done_c = -1;
    int end_c;
    for (int c = 0; c < W; c++) begin
      e_re[d][c] = 0; e_addr[d][c] = '0; e_we[d][c] = 0;
      e_mode[d][c] = 3'd0; e_busy[d][c] = 0; e_done[d][c] = 0;
    end
    if (d == 0) exp_q0.delete(); else exp_q1.delete();
    if (ab == 0) return;
    if (n == 0) done_c = 1;
    else begin
      for (int c = 2; c < W && issued < n; c++) begin
        logic [AW-1:0] a;
        a = b + AW'(issued);
        if (ab > 0 && c >= ab) break;
        if (!h[c]) begin
          e_re[d][c] = 1; e_addr[d][c] = a;
          if (c + lat + 1 < W && (ab < 0 || c + lat + 1 <= ab)) begin
            e_we[d][c+lat+1] = 1;
            if (d == 0) exp_q0.push_back(mem(a)); else exp_q1.push_back(mem(a));
          end
          issued++; last = c;
        end
      end
      done_c = last + lat + 2 + FR;
    end
    end_c = (ab > 0) ? ab : done_c;
    for (int c = 1; c <= end_c && c < W; c++) begin
      e_busy[d][c] = 1;
      if (n != 0 && (ab > 0 || c < done_c)) e_mode[d][c] = 3'd1;
    end
    if (ab < 0 && done_c < W) e_done[d][done_c] = 1;
    exp_rows[d] = (d == 0) ? exp_q0.size() : exp_q1.size();
  endtask

  task automatic sample_check(input int c);
    for (int d = 0; d < 2; d++) begin
      logic o_re, o_we, o_busy, o_done;
      logic [AW-1:0] o_addr;
      logic [DW-1:0] o_data, x;
      logic [2:0] o_mode;
      o_re   = d ? sre_b   : sre_a;   o_addr = d ? saddr_b : saddr_a;
      o_we   = d ? bwe_b   : bwe_a;   o_data = d ? odata_b : odata_a;
      o_mode = d ? bmode_b : bmode_a; o_busy = d ? busy_b  : busy_a;
      o_done = d ? done_b  : done_a;
      chk($sformatf("lat%0d sram_re", d + 1), c, DW'(o_re), DW'(e_re[d][c]));
      chk($sformatf("lat%0d sram_addr", d + 1), c, DW'(o_addr), DW'(e_addr[d][c]));
      chk($sformatf("lat%0d buffer_we", d + 1), c, DW'(o_we), DW'(e_we[d][c]));
      chk($sformatf("lat%0d buffer_mode", d + 1), c, DW'(o_mode), DW'(e_mode[d][c]));
      chk($sformatf("lat%0d busy", d + 1), c, DW'(o_busy), DW'(e_busy[d][c]));
      chk($sformatf("lat%0d done", d + 1), c, DW'(o_done), DW'(e_done[d][c]));
      if (o_we) begin
        x = 'x;
        if (d == 0 && exp_q0.size() > 0) x = exp_q0.pop_front();
        if (d == 1 && exp_q1.size() > 0) x = exp_q1.pop_front();
        chk($sformatf("lat%0d row_data", d + 1), c, o_data, x);
      end else begin
        chk($sformatf("lat%0d idle_data", d + 1), c, o_data, '0);
      end
      if (d == 0 && o_done && obs_done_a < 0) obs_done_a = c;
      if (d == 0 && o_we && first_we_a < 0) first_we_a = c;
    end
  endtask

  task automatic check_idle(input string tag, input bit cnt_zero);
    chk({tag, " sram_re"}, 0, DW'({sre_a, sre_b}), '0);
    chk({tag, " sram_addr"}, 0, DW'({saddr_a, saddr_b}), '0);
    chk({tag, " buffer_we"}, 0, DW'({bwe_a, bwe_b}), '0);
    chk({tag, " out_data"}, 0, odata_a | odata_b, '0);
    chk({tag, " mode"}, 0, DW'({bmode_a, bmode_b}), '0);
    chk({tag, " busy_done"}, 0, DW'({busy_a, busy_b, done_a, done_b}), '0);
    if (cnt_zero) chk({tag, " rows_out"}, 0, DW'({rows_out_a, rows_out_b}), '0);
  endtask

  // One run of W cycles; caller has filled h[]. ab = abort cycle (-1 none), xs = extra start.
  task automatic run(input logic [AW-1:0] b, input int n, input int ab, input int xs);
    build_exp(0, 1, b, n, ab);
    build_exp(1, 2, b, n, ab);
    obs_done_a = -1; first_we_a = -1;
    for (int c = 0; c < W; c++) begin
      start = (c == 0) || (c == xs);
      abort = (c == ab);
      hold  = h[c];
      if (c == 0) begin base_addr = b; num_rows = AW'(n); end
      else begin base_addr = AW'($urandom); num_rows = AW'($urandom_range(0, 15)); end
      @(negedge clk);
      sample_check(c);
      @(posedge clk); #1;
    end
    start = 0; abort = 0; hold = 0;
    chk("lat1 rows_left", 0, DW'(exp_q0.size()), '0);
    chk("lat2 rows_left", 0, DW'(exp_q1.size()), '0);
`ifdef GAUSS_ROW_FETCH_CNT_EN
    chk("lat1 rows_out", 0, DW'(rows_out_a), DW'(exp_rows[0]));
    chk("lat2 rows_out", 0, DW'(rows_out_b), DW'(exp_rows[1]));
`endif
  endtask

  task automatic clear_hold();
    for (int c = 0; c < W; c++) h[c] = 0;
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; hold = 0; base_addr = '0; num_rows = '0;
    exp_rows[0] = 0; exp_rows[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 1);
    @(posedge clk); #1;
    rst = 0;

    // Basic run: done at cycle 16, first row at cycle 4.
    clear_hold();
    run(10'h010, 3, -1, -1);
    chk("basic done_cycle", 0, DW'(obs_done_a), DW'(16));
    chk("basic first_we", 0, DW'(first_we_a), DW'(4));

    // Hold in cycles 3-4 delays done by two cycles.
    clear_hold(); h[3] = 1; h[4] = 1;
    run(10'h010, 3, -1, -1);
    chk("hold done_cycle", 0, DW'(obs_done_a), DW'(18));

    clear_hold();
    run(10'h155, 0, -1, -1);
    chk("zero done_cycle", 0, DW'(obs_done_a), DW'(1));

    run(10'h3FE, 4, -1, -1);
    run(10'h020, 5, 3, -1);
    run(10'h040, 2, -1, -1);
    run(10'h060, 4, 0, -1);
    run(10'h080, 3, -1, 2);

    // Reset while fetching.
    start = 1; base_addr = 10'h100; num_rows = 10'd6;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_idle("mid_reset", 1);
    @(posedge clk); #1;
    exp_rows[0] = 0; exp_rows[1] = 0;

    for (int r = 0; r < 20; r++) begin
      int n, ab, xs;
      n  = $urandom_range(0, 10);
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 2 + n)) : -1;
      xs = (n > 0) ? int'($urandom_range(1, 3)) : -1;
      for (int c = 0; c < W; c++) h[c] = (c < 30) && ($urandom_range(0, 2) == 0);
      run(AW'($urandom), n, ab, xs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
